multi_timer: RTL

- Parametrised multi-channel programmable tick/timer generator.
- Each channel counts prescaled clock-enable strobes up to a programmable terminal value, then emits a one-cycle tick.
- Channels run in periodic or one-shot mode, each with a sticky interrupt flag.
- Sits beside the VGA timing and control logic as the shared source for frame, blink and delay strobes.

---
 rtl/multi_timer.sv | 113 +++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// Multi-channel programmable tick generator driven by one shared clock-enable prescaler.
// Each channel counts strobes up to its terminal value, pulses tick and latches a sticky irq.
module multi_timer #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned PRESC_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PRESC_W-1:0]  presc_div,
   input  logic                set,
   input  logic [SEL_W-1:0]    sel,
   input  logic [WIDTH-1:0]    val1,
   input  logic                mode,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] stop,
   input  logic [CHANNELS-1:0] irq_clr,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] irq,
   output logic [CHANNELS-1:0] busy,
   output logic [WIDTH-1:0]    cnt_out
);

   logic [PRESC_W-1:0]             pcnt_q, pcnt_d;
   logic                           ce;
   logic [CHANNELS-1:0]            wr;
   logic [CHANNELS-1:0][WIDTH-1:0] term_q, term_d;
   logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
   logic [CHANNELS-1:0]            mode_q, mode_d;
   logic [CHANNELS-1:0]            busy_q, busy_d;
   logic [CHANNELS-1:0]            tick_q, tick_d;
   logic [CHANNELS-1:0]            irq_q, irq_d;

   // Shared prescaler: compare against the live divisor so a lowered value never stalls.
   always_comb begin
      ce     = (pcnt_q >= presc_div);
      pcnt_d = ce ? '0 : pcnt_q + PRESC_W'(1);
   end

   // One-hot config write; an out-of-range select shifts out and writes nothing.
   assign wr = set ? (CHANNELS'(1) << sel) : '0;

   // Per-channel next state: config write, then stop > start > counting.
   always_comb begin
      term_d  = term_q;
      mode_d  = mode_q;
      count_d = count_q;
      busy_d  = busy_q;
      tick_d  = '0;
      irq_d   = irq_q & ~irq_clr;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (wr[i]) begin
            term_d[i]  = val1;
            mode_d[i]  = mode;
            count_d[i] = '0;
         end
         if (stop[i]) begin
            busy_d[i] = 1'b0;
         end else if (start[i]) begin
            busy_d[i]  = 1'b1;
            count_d[i] = '0;
         end else if (busy_q[i] && ce && !wr[i]) begin
            if (count_q[i] == term_q[i]) begin
               tick_d[i]  = 1'b1;
               count_d[i] = '0;
               if (mode_q[i]) begin
                  busy_d[i] = 1'b0;
               end
            end else begin
               count_d[i] = count_q[i] + WIDTH'(1);
            end
         end
         // A terminal event in the same cycle as a clear keeps the flag set.
         irq_d[i] = irq_d[i] | tick_d[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_q  <= '0;
         term_q  <= '0;
         mode_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         tick_q  <= '0;
         irq_q   <= '0;
      end else begin
         pcnt_q  <= pcnt_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         tick_q  <= tick_d;
         irq_q   <= irq_d;
      end
   end

   assign tick = tick_q;
   assign irq  = irq_q;
   assign busy = busy_q;

   // Count readback mux; unmapped selects read as zero.
   always_comb begin
      cnt_out = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (int'(sel) == i) begin
            cnt_out = count_q[i];
         end
      end
   end

endmodule
